// File: rtl/wb_master_pkg.sv
// Shared types and default widths for the Wishbone classic master bridge.
// Optional bus-wait timeout is enabled with macro WB_MASTER_TIMEOUT_EN.
package wb_master_pkg;

    localparam int unsigned WB_ADDR_W_DEF = 32;
    localparam int unsigned WB_DATA_W_DEF = 32;

    // Bridge control states: wait for command, run bus cycle, hold response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/wb_master_wdog.sv
// Bus-wait watchdog for wb_master_bridge (used only when WB_MASTER_TIMEOUT_EN
// is defined). Counts BUS cycles without ack and flags the cycle in which the
// count reaches LIMIT, so the bridge can abort on that same edge.
module wb_master_wdog #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Next count: clear on entry to BUS, otherwise step once per un-acked BUS cycle
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (cnt_en_i) begin
            count_d = count_q + 8'd1;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Fires when this cycle's increment brings the count to LIMIT
    assign expired_o = cnt_en_i && !clear_i && (count_q == LAST);

endmodule

// File: rtl/wb_master_bridge.sv
// Command/response to Wishbone classic master bridge. One bus cycle per
// accepted command, no overlap; all outputs registered.
// Define WB_MASTER_TIMEOUT_EN to abort a bus cycle after TIMEOUT_CYCLES
// un-acked cycles with an error response.
module wb_master_bridge
    import wb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = WB_ADDR_W_DEF,
    parameter int unsigned DATA_W         = WB_DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wb_cyc,
    output logic              wb_stb,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("wb_master_bridge: TIMEOUT_CYCLES must be within 1..255");
    end

    state_e              state_q;
    logic                cmd_ready_q;
    logic                wb_cyc_q;
    logic                wb_stb_q;
    logic                wb_we_q;
    logic [ADDR_W-1:0]   wb_addr_q;
    logic [DATA_W-1:0]   wb_data_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;

    logic                accept;
    logic                timeout_hit;

    assign accept = cmd_valid && cmd_ready_q;

`ifdef WB_MASTER_TIMEOUT_EN
    logic wait_cycle;
    assign wait_cycle = (state_q == BUS) && !wb_ack;

    wb_master_wdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .cnt_en_i  (wait_cycle),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Control FSM; every output is a register updated here
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            wb_cyc_q    <= 1'b0;
            wb_stb_q    <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (accept) begin
                        cmd_ready_q <= 1'b0;
                        wb_we_q     <= cmd_we;
                        wb_addr_q   <= cmd_addr;
                        wb_data_q   <= cmd_wdata;
                        wb_cyc_q    <= 1'b1;
                        wb_stb_q    <= 1'b1;
                        state_q     <= BUS;
                    end
                end
                BUS: begin
                    // Ack wins over a timeout expiring on the same edge
                    if (wb_ack) begin
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= wb_we_q ? '0 : wb_data_i;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (timeout_hit) begin
                        wb_cyc_q    <= 1'b0;
                        wb_stb_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign wb_cyc    = wb_cyc_q;
    assign wb_stb    = wb_stb_q;
    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data_o = wb_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Self-checking bench for wb_master_bridge. Exercises the timeout path only
// when WB_MASTER_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES = 4).
module tb_wb_master_bridge;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int          TO = 4;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          wb_cyc;
    logic          wb_stb;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data_o;
    logic [DW-1:0] wb_data_i;
    logic          wb_ack;

    int errors = 0;
    int checks = 0;

    // Expected outcome of one command, derived from the slave's behaviour
    typedef struct {
        logic [DW-1:0] rdata;
        bit            err;
        int            bus_cycles;
    } exp_t;
    exp_t exp_q[$];

    wb_master_bridge #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data_o (wb_data_o),
        .wb_data_i (wb_data_i),
        .wb_ack    (wb_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One command: slave acks after wait_n wait cycles with data rd,
    // consumer holds off the response for hold cycles.
    task automatic do_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rd, input int wait_n, input int hold);
        exp_t e;
        exp_t got;
        int   n;
        bit   tmo;
        tmo          = TO_EN && (wait_n >= TO);
        e.bus_cycles = tmo ? TO : wait_n + 1;
        e.err        = tmo;
        e.rdata      = (we || tmo) ? '0 : rd;
        exp_q.push_back(e);

        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        check("busy_cmd_ready", cmd_ready, 0);

        n = 0;
        while (wb_cyc === 1'b1 && n < 64) begin
            n++;
            check("bus_stb", wb_stb, 1);
            check("bus_we", wb_we, we);
            check("bus_addr", wb_addr, addr);
            check("bus_wdata", wb_data_o, wdata);
            check("bus_rsp_valid", rsp_valid, 0);
            wb_ack    = (n == wait_n + 1);
            wb_data_i = wb_ack ? rd : $urandom;
            rsp_ready = 1'($urandom);
            tick();
        end
        wb_ack    = 1'b0;
        wb_data_i = $urandom;

        got = exp_q.pop_front();
        check("bus_cycles", n, got.bus_cycles);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_rdata", rsp_rdata, got.rdata);
        check("rsp_err", rsp_err, got.err);
        check("rsp_stb_low", wb_stb, 0);

        for (int k = 0; k < hold; k++) begin
            rsp_ready = 1'b0;
            cmd_valid = 1'b1;
            wb_ack    = 1'($urandom);
            tick();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_rdata", rsp_rdata, got.rdata);
            check("hold_rsp_err", rsp_err, got.err);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_wb_cyc", wb_cyc, 0);
        end
        cmd_valid = 1'b0;
        wb_ack    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("done_rsp_valid", rsp_valid, 0);
        check("done_cmd_ready", cmd_ready, 1);
        check("done_wb_cyc", wb_cyc, 0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        wb_data_i = '0;
        wb_ack    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wb_cyc", wb_cyc, 0);
        check("rst_wb_stb", wb_stb, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Stray ack while idle must do nothing
        wb_ack = 1'b1;
        tick();
        tick();
        wb_ack = 1'b0;
        check("idle_ack_cyc", wb_cyc, 0);
        check("idle_ack_rsp", rsp_valid, 0);

        // Read with immediate ack, then write with 3 wait cycles
        do_txn(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0005, 0, 0);
        do_txn(1'b1, 32'h0000_0004, 32'h0000_0001, 32'hDEAD_BEEF, 3, 0);

        // Response backpressure for 5 cycles
        do_txn(1'b0, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 5);
        do_txn(1'b1, 32'h0000_0108, 32'hCAFE_F00D, 32'h0, 0, 0);

        // Timeout with a late ack during the held response
        if (TO_EN) begin
            do_txn(1'b0, 32'h0000_0200, 32'h0, 32'hAAAA_5555, 255, 3);
        end

        // Reset during the second BUS cycle
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 32'h0000_0300;
        tick();
        cmd_valid = 1'b0;
        check("rbus_cyc1", wb_cyc, 1);
        tick();
        check("rbus_cyc2", wb_cyc, 1);
        rst = 1'b1;
        tick();
        check("rbus_cyc_drop", wb_cyc, 0);
        check("rbus_stb_drop", wb_stb, 0);
        check("rbus_no_rsp", rsp_valid, 0);
        rst = 1'b0;
        tick();
        check("rbus_cmd_ready", cmd_ready, 1);
        check("rbus_no_rsp2", rsp_valid, 0);

        // Reset while a response is pending discards it
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wb_ack    = 1'b1;
        wb_data_i = 32'h5A5A_0001;
        tick();
        wb_ack    = 1'b0;
        rsp_ready = 1'b0;
        check("rresp_valid", rsp_valid, 1);
        rst = 1'b1;
        tick();
        check("rresp_dropped", rsp_valid, 0);
        check("rresp_rdata", rsp_rdata, 0);
        rst = 1'b0;
        tick();
        check("rresp_cmd_ready", cmd_ready, 1);
        rsp_ready = 1'b1;

        // Back-to-back reads with the consumer always ready
        for (int i = 0; i < 8; i++) begin
            do_txn(1'b0, 32'(i * 4), 32'h0, $urandom, 0, 0);
        end

        // Random mix
        for (int i = 0; i < 16; i++) begin
            do_txn(1'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

Interface
REQ-001 Parameter ADDR_W, default 32: command and Wishbone address width.
REQ-002 Parameter DATA_W, default 32: command, response and Wishbone data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16: maximum bus-wait cycles before abort; legal range 1..255.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 cmd_valid  input  1  command request present.
REQ-007 cmd_ready  output  1  bridge accepts a command this cycle.
REQ-008 cmd_we  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  target byte address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-014 rsp_err  output  1  transaction aborted by timeout.
REQ-015 wb_cyc, wb_stb, wb_we  output  1 each  Wishbone classic master controls.
REQ-016 wb_addr  output  ADDR_W  Wishbone address.
REQ-017 wb_data_o  output  DATA_W  Wishbone write data.
REQ-018 wb_data_i  input  DATA_W  Wishbone read data.
REQ-019 wb_ack  input  1  slave acknowledge.

Function
REQ-020 The FSM SHALL have the states IDLE, BUS and RESP. All outputs SHALL be registered.
REQ-021 cmd_ready SHALL be 1 only in IDLE. A handshake (cmd_valid & cmd_ready) at cycle T SHALL latch we, addr and wdata, and move the FSM to BUS.
REQ-022 In BUS, starting at T+1, wb_cyc = wb_stb = 1, and wb_we, wb_addr and wb_data_o SHALL hold the latched values, stable until the FSM leaves BUS.
REQ-023 When wb_ack = 1 is sampled in BUS, the next cycle SHALL have wb_cyc = wb_stb = 0 and rsp_valid = 1. rsp_rdata SHALL be wb_data_i as sampled with the ack for reads, or 0 for writes. rsp_err SHALL be 0. The FSM moves to RESP.
REQ-024 Minimum command-to-response latency SHALL be 2 cycles, reached when the slave acks in the first BUS cycle.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold until rsp_ready = 1. On that cycle the FSM returns to IDLE, rsp_valid clears next cycle, and cmd_ready rises next cycle.
REQ-026 wb_ack outside BUS SHALL be ignored, with no state or output change.
REQ-027 Exactly one Wishbone cycle SHALL be issued per accepted command. Commands are never pipelined or overlapped.
REQ-028 wb_we, wb_addr and wb_data_o outside BUS SHALL hold their last values. The bench checks them only while wb_cyc = 1.

Reset
REQ-029 rst = 1 at a clock edge SHALL force:
- state IDLE; wb_cyc = wb_stb = wb_we = 0; wb_addr = wb_data_o = 0;
- rsp_valid = rsp_err = 0; rsp_rdata = 0; timeout count 0.
REQ-030 cmd_ready SHALL be 0 while rst = 1 and 1 in the first cycle after release.
REQ-031 Reset asserted mid-BUS SHALL drop wb_cyc and wb_stb at that edge, with no response produced. Reset asserted mid-RESP SHALL discard the pending response.

Configuration
REQ-032 Macro WB_MASTER_TIMEOUT_EN, when defined, SHALL enable the following:
- a counter that clears on entry to BUS and increments each BUS cycle without ack;
- when the count reaches TIMEOUT_CYCLES, the next cycle drops wb_cyc and wb_stb and presents rsp_valid = 1, rsp_err = 1, rsp_rdata = 0 (state RESP).
REQ-033 An ack sampled in the same cycle the count reaches TIMEOUT_CYCLES SHALL take priority and yield a normal response.
REQ-034 Without the macro, BUS SHALL wait indefinitely, rsp_err SHALL be constant 0, and no counter logic SHALL be synthesized.

Structure
REQ-035 Package wb_master_pkg SHALL hold the state enum (IDLE/BUS/RESP) and the default ADDR_W/DATA_W constants.
REQ-036 The timeout counter SHALL be a sub-module, wb_master_wdog (inputs clear, count-enable; output expired), instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-037 Read, immediate ack: read addr 0x0000_0000; slave acks the first BUS cycle with 0x0000_0005 -> rsp_valid two cycles after the handshake, rsp_rdata = 0x5, rsp_err = 0, exactly one ack cycle.
REQ-038 Write, delayed ack: write 0x0000_0004 <- 0x1; ack after 3 wait cycles -> wb_cyc high 4 cycles, wb_we = 1, wb_data_o = 0x1 throughout, rsp_rdata = 0.
REQ-039 Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready = 0 and cmd_valid ignored until release, then next command accepted the cycle after.
REQ-040 Timeout, macro on, TIMEOUT_CYCLES = 4: no ack -> wb_cyc drops after 4 BUS cycles, rsp_err = 1, rsp_rdata = 0; a late ack afterwards is ignored.
REQ-041 Reset mid-BUS: assert rst during the second BUS cycle -> wb_cyc = 0 at that edge, no rsp_valid, cmd_ready = 1 the cycle after release.
REQ-042 Back-to-back: 8 reads against the timer slave with rsp_ready tied 1 -> 8 responses in order, each with exactly one ack per cycle.
